// File: rtl/mqst_byte_deframer.sv
// Receive-side byte deframer: hunts for a sync byte in a serial bit stream,
// reads a length byte, then emits that many payload bytes as single-cycle pulses.
`timescale 1ns/1ps
module mqst_byte_deframer #(
   parameter logic [7:0]  SYNC_WORD   = 8'hD5,
   parameter int unsigned GAP_TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Bit_in,
   input  logic       Bit_in_valid,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   output logic       frame_start,
   output logic       frame_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned    GAP_W   = $clog2(GAP_TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_TIMEOUT);

   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

   state_t           state, state_d;
   logic [7:0]       sh;
   logic [7:0]       sh_next;
   logic [2:0]       bit_cnt;
   logic [7:0]       byte_rem;
   logic [GAP_W-1:0] gap_cnt;

   logic byte_last, gap_expired;
   logic start_d, done_d, err_d, dv_d, load_len, clr_bits;

   // sh_next is the byte as it will look once this cycle's bit is shifted in.
   assign sh_next     = {sh[6:0], Bit_in};
   assign byte_last   = Bit_in_valid && (bit_cnt == 3'd7);
   assign gap_expired = !Bit_in_valid && (gap_cnt == GAP_MAX);
   assign busy        = (state != HUNT);

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d  = state;
      start_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      dv_d     = 1'b0;
      load_len = 1'b0;
      clr_bits = 1'b0;
      case (state)
         HUNT: begin
            if (Bit_in_valid && (sh_next == SYNC_WORD)) begin
               state_d  = LEN;
               clr_bits = 1'b1;
            end
         end
         LEN: begin
            if (byte_last) begin
               if (sh_next == 8'h00) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  start_d  = 1'b1;
                  load_len = 1'b1;
                  state_d  = PAYLOAD;
               end
            end else if (gap_expired) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end
         end
         PAYLOAD: begin
            // A sync pattern inside the payload is ordinary data here.
            if (byte_last) begin
               dv_d = 1'b1;
               if (byte_rem == 8'd1) begin
                  done_d  = 1'b1;
                  state_d = HUNT;
               end
            end else if (gap_expired) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HUNT;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh             <= 8'h00;
         bit_cnt        <= 3'd0;
         byte_rem       <= 8'h00;
         gap_cnt        <= '0;
         data_out       <= 8'h00;
         data_out_valid <= 1'b0;
         frame_start    <= 1'b0;
         frame_done     <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         data_out_valid <= dv_d;
         frame_start    <= start_d;
         frame_done     <= done_d;
         frame_err      <= err_d;
         if (Bit_in_valid) begin
            sh      <= sh_next;
            bit_cnt <= clr_bits ? 3'd0 : bit_cnt + 3'd1;
         end
         if (load_len) byte_rem <= sh_next;
         if (dv_d) begin
            data_out <= sh_next;
            byte_rem <= byte_rem - 8'd1;
         end
         // Idle-gap counter only matters inside a frame; it rests at zero in HUNT.
         if (Bit_in_valid || (state_d == HUNT)) gap_cnt <= '0;
         else if (gap_cnt != GAP_MAX)           gap_cnt <= gap_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mqst_byte_deframer.sv
// Self-checking bench for mqst_byte_deframer: a bit-history / bit-queue model
// predicts every output each cycle; directed frames pin the model with literals.
`timescale 1ns/1ps
module tb_mqst_byte_deframer;

   localparam int G = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Bit_in;
   logic       Bit_in_valid;
   logic [7:0] data_out;
   logic       data_out_valid, frame_start, frame_done, frame_err, busy;

   mqst_byte_deframer #(.SYNC_WORD(8'hD5), .GAP_TIMEOUT(G)) dut (
      .clk(clk), .rst_n(rst_n), .Bit_in(Bit_in), .Bit_in_valid(Bit_in_valid),
      .data_out(data_out), .data_out_valid(data_out_valid),
      .frame_start(frame_start), .frame_done(frame_done),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] exp_dout = 8'h00;
   logic exp_dv = 0, exp_start = 0, exp_done = 0, exp_err = 0, exp_busy = 0;

   initial begin
      int         phase;      // 0 hunting, 1 expecting length, 2 in payload
      logic [7:0] window;     // last eight received bits
      bit         bits[$];    // bits of the byte being collected
      int         remaining, cyc, last_bit;
      logic [7:0] b;
      phase = 0; window = 0; remaining = 0; cyc = 0; last_bit = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            phase = 0; window = 0; bits.delete(); remaining = 0; cyc = 0; last_bit = 0;
            exp_dout = 0; exp_dv = 0; exp_start = 0; exp_done = 0; exp_err = 0; exp_busy = 0;
         end else begin
            cyc++;
            exp_dv = 0; exp_start = 0; exp_done = 0; exp_err = 0;
            if (Bit_in_valid) begin
               window   = {window[6:0], Bit_in};
               last_bit = cyc;
               if (phase == 0) begin
                  if (window == 8'hD5) begin
                     phase = 1;
                     bits.delete();
                  end
               end else begin
                  bits.push_back(Bit_in);
                  if (bits.size() == 8) begin
                     b = 0;
                     foreach (bits[i]) b = {b[6:0], bits[i]};
                     bits.delete();
                     if (phase == 1) begin
                        if (b == 0) begin exp_err = 1; phase = 0; end
                        else begin exp_start = 1; remaining = int'(b); phase = 2; end
                     end else begin
                        exp_dv = 1; exp_dout = b; remaining--;
                        if (remaining == 0) begin exp_done = 1; phase = 0; end
                     end
                  end
               end
            end else if (phase != 0 && cyc - last_bit == G + 1) begin
               exp_err = 1;
               phase   = 0;
            end
            exp_busy = (phase != 0);
         end
      end
   end

   // ---------------- compare + event log ----------------
   logic [7:0] got[$];
   int n_start = 0, n_done = 0, n_err = 0;

   initial begin
      forever begin
         @(negedge clk);
         check("data_out",       data_out,       exp_dout);
         check("data_out_valid", data_out_valid, exp_dv);
         check("frame_start",    frame_start,    exp_start);
         check("frame_done",     frame_done,     exp_done);
         check("frame_err",      frame_err,      exp_err);
         check("busy",           busy,           exp_busy);
         if (data_out_valid) got.push_back(data_out);
         if (frame_start) n_start++;
         if (frame_done)  n_done++;
         if (frame_err)   n_err++;
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic send_bit(input logic b, input int gap);
      Bit_in       = b;
      Bit_in_valid = 1'b1;
      @(negedge clk);
      Bit_in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      got.delete();
      n_start = 0; n_done = 0; n_err = 0;
   endtask

   function automatic int rand_gap();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 15) return r % 4;
      return G - 2 + (r - 15);
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed and random sequences ----------------
   initial begin
      int k_err, bad;
      logic [7:0] pb;
      Bit_in = 1'b0; Bit_in_valid = 1'b0; rst_n = 1'b1;
      #1 rst_n = 1'b0;
      idle(3);
      check("reset_data_out", data_out, 8'h00);
      check("reset_busy", busy, 1'b0);
      check("reset_pulses", {data_out_valid, frame_start, frame_done, frame_err}, 4'b0000);
      rst_n = 1'b1;
      idle(2);

      // Basic three-byte frame, bits eight cycles apart.
      clear_log();
      send_byte(8'hD5, 7); send_byte(8'h03, 7);
      send_byte(8'h11, 7); send_byte(8'h22, 7); send_byte(8'h33, 7);
      idle(5);
      check("t1_starts", n_start, 1);
      check("t1_count", got.size(), 3);
      check("t1_b0", got[0], 8'h11);
      check("t1_b1", got[1], 8'h22);
      check("t1_b2", got[2], 8'h33);
      check("t1_done", n_done, 1);
      check("t1_err", n_err, 0);

      // Junk before sync; sync byte inside payload is data.
      clear_log();
      send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
      send_byte(8'hD5, 1); send_byte(8'h01, 1); send_byte(8'hD5, 1);
      idle(5);
      check("t2_count", got.size(), 1);
      check("t2_b0", got[0], 8'hD5);
      check("t2_done", n_done, 1);

      // Zero length, then a good frame.
      clear_log();
      send_byte(8'hD5, 1); send_byte(8'h00, 1);
      idle(3);
      check("t3_err", n_err, 1);
      check("t3_nostart", n_start, 0);
      send_byte(8'hD5, 1); send_byte(8'h01, 1); send_byte(8'hAA, 1);
      idle(5);
      check("t3_count", got.size(), 1);
      check("t3_b0", got[0], 8'hAA);

      // Timeout after a partial second byte; error exactly G+1 cycles later.
      clear_log();
      send_byte(8'hD5, 2); send_byte(8'h02, 2); send_byte(8'h5A, 2);
      send_bit(1, 2); send_bit(0, 2); send_bit(1, 2); send_bit(1, 0);
      k_err = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (frame_err && k_err < 0) k_err = k;
      end
      check("t4_err_delay", k_err, G + 1);
      check("t4_count", got.size(), 1);
      check("t4_b0", got[0], 8'h5A);
      check("t4_nodone", n_done, 0);
      check("t4_err", n_err, 1);

      // Bit arriving on the expiry cycle wins; one cycle later it does not.
      clear_log();
      send_byte(8'hD5, 1); send_byte(8'h01, 1);
      pb = 8'h3C;
      for (int j = 7; j >= 0; j--) send_bit(pb[j], (j == 4) ? G : 1);
      idle(5);
      check("t5_win_err", n_err, 0);
      check("t5_win_b0", got[0], 8'h3C);
      clear_log();
      send_byte(8'hD5, 1); send_byte(8'h01, 1);
      for (int j = 7; j >= 0; j--) send_bit(pb[j], (j == 4) ? G + 1 : 1);
      idle(5);
      check("t5_lose_err", n_err, 1);
      check("t5_lose_count", got.size(), 0);

      // Maximum frame with a bit every cycle.
      clear_log();
      send_byte(8'hD5, 0); send_byte(8'hFF, 0);
      for (int i = 0; i < 255; i++) send_byte(8'(i), 0);
      idle(5);
      check("t6_count", got.size(), 255);
      bad = 0;
      foreach (got[i]) if (got[i] != 8'(i)) bad++;
      check("t6_values", bad, 0);
      check("t6_done", n_done, 1);

      // Asynchronous reset mid-frame, then a clean frame.
      clear_log();
      send_byte(8'hD5, 1); send_byte(8'h02, 1);
      send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
      check("t7_busy_before", busy, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      check("t7_rst_busy", busy, 1'b0);
      check("t7_rst_data", data_out, 8'h00);
      check("t7_rst_pulses", {data_out_valid, frame_start, frame_done, frame_err}, 4'b0000);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      send_byte(8'hD5, 1); send_byte(8'h01, 1); send_byte(8'h77, 1);
      idle(5);
      check("t7_count", got.size(), 1);
      check("t7_b0", got[0], 8'h77);
      check("t7_err", n_err, 0);

      // Randomized frames: junk, zero lengths, aborts, gaps near the timeout.
      for (int f = 0; f < 30; f++) begin
         int nj, len, abort_at, bitn;
         bit abort, aborted;
         nj = int'($urandom_range(0, 5));
         repeat (nj) send_bit(1'($urandom_range(0, 1)), rand_gap());
         send_byte(8'hD5, rand_gap());
         len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
         send_byte(8'(len), rand_gap());
         abort    = ($urandom_range(0, 5) == 0) && (len > 0);
         abort_at = (len > 0) ? int'($urandom_range(0, len * 8 - 1)) : 0;
         aborted  = 0;
         bitn     = 0;
         for (int i = 0; i < len; i++) begin
            pb = 8'($urandom_range(0, 255));
            for (int j = 7; j >= 0; j--) begin
               if (!aborted) begin
                  if (abort && bitn == abort_at) begin
                     idle(G + 3);
                     aborted = 1;
                  end else begin
                     send_bit(pb[j], rand_gap());
                  end
                  bitn++;
               end
            end
         end
         idle(int'($urandom_range(0, 3)));
      end
      idle(G + 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mqst_byte_deframer.md
# mqst_byte_deframer

Receive-side byte deframer sitting directly downstream of the Manchester decoder (`Mqst_Demodule`) in the Manchester link. It consumes the decoder's 1-bit stream (`Bit_in`/`Bit_in_valid`, MSB first, matching the transmit serializer), hunts for a sync byte, then reads a length byte and emits that many payload bytes as single-cycle `data_out_valid` pulses. It drives the `data_out`/`data_out_valid` outputs of the link top level and flags malformed or stalled frames.

## Interface
- `SYNC_WORD`, 8'hD5: frame delimiter byte searched for bit-by-bit.
- `GAP_TIMEOUT`, 4096: idle clock cycles without `Bit_in_valid` that abort a frame in progress; must be ≥ 2.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: reset, asynchronous, active-low.
- `Bit_in` input 1: decoded bit from the Manchester decoder.
- `Bit_in_valid` input 1: `Bit_in` is valid this cycle; one bit per pulse, any spacing.
- `data_out` output 8: assembled payload byte, MSB = first received bit.
- `data_out_valid` output 1: one-cycle pulse, `data_out` valid.
- `frame_start` output 1: one-cycle pulse when a non-zero length byte is accepted.
- `frame_done` output 1: one-cycle pulse coincident with the last payload byte's `data_out_valid`.
- `frame_err` output 1: one-cycle pulse on timeout mid-frame or zero length byte.
- `busy` output 1: high in every state except HUNT.

## Operation
- Shift register `sh[7:0]`: on each `Bit_in_valid`, `sh <= {sh[6:0], Bit_in}`; bit counter `bit_cnt[2:0]` increments, wraps 7→0.
- States: HUNT, LEN, PAYLOAD.
- HUNT: compare next value `{sh[6:0], Bit_in}` with `SYNC_WORD` on each valid bit; on match go to LEN, clear `bit_cnt`. Sliding match — no byte alignment assumed in HUNT. `bit_cnt` is don't-care in HUNT.
- LEN: on the 8th valid bit, byte `L` = `{sh[6:0], Bit_in}`. L=0 → pulse `frame_err`, go to HUNT. L≠0 → load `byte_rem <= L`, pulse `frame_start`, go to PAYLOAD.
- PAYLOAD: on each 8th valid bit, register byte into `data_out`, pulse `data_out_valid`, decrement `byte_rem`. When `byte_rem` was 1: also pulse `frame_done`, go to HUNT. Sync word occurring in payload is data, not a delimiter.
- Gap counter: cleared on every `Bit_in_valid`, else increments, saturates at `GAP_TIMEOUT`. Counter only meaningful outside HUNT; cleared on entry to HUNT.
- Timeout: in LEN or PAYLOAD, counter reaching `GAP_TIMEOUT` with no `Bit_in_valid` that cycle → pulse `frame_err`, go to HUNT, discard partial byte. A `Bit_in_valid` in the same cycle the counter would expire wins: bit is taken, no error.
- On return to HUNT `sh` is kept, so a sync word straddling the frame tail is not required to be found; HUNT restarts matching from the next bit.

## Timing
- Reset values: `data_out`=8'h00, `data_out_valid`=0, `frame_start`=0, `frame_done`=0, `frame_err`=0, `busy`=0; state HUNT; `sh`=0; counters 0.
- Reset asserted mid-frame: immediate return to reset values, no `frame_err`/`frame_done` pulse.
- Latency: outputs are registered; every pulse appears the cycle after the `Bit_in_valid` carrying the byte's 8th bit.
- `data_out` holds its last value between pulses.
- `busy` rises the cycle after the sync match; falls the cycle `frame_done` or `frame_err` is high.
- Maximum frame: 255 payload bytes; back-to-back frames need only the next `SYNC_WORD` (no gap).
- Timeout reported exactly `GAP_TIMEOUT`+1 cycles after the last `Bit_in_valid`.
- Continuous `Bit_in_valid` every cycle supported (no throughput bubbles).

## Test plan
- Bits for D5, 03, 11, 22, 33 spaced 8 cycles → `frame_start` after 03; `data_out_valid` ×3 with 11, 22, 33; `frame_done` with 33; `frame_err` never.
- Junk bits 1,0,1 then D5, 01, D5 → single byte D5 output, `frame_done`; embedded sync not treated as delimiter.
- D5, 00 → `frame_err` pulse, no `frame_start`, `busy` low next cycle; following D5, 01, AA frame decodes AA.
- D5, 02, 5A then 4 bits then silence, `GAP_TIMEOUT`=16 → 5A output, `frame_err` 17 cycles after last bit, no `frame_done`.
- `Bit_in_valid` every cycle, D5, FF, 255 bytes 00..FE → 255 consecutive-by-8 pulses, values 00..FE, `frame_done` on FE.
- `rst_n` low after 3 payload bits of D5, 02, … → all outputs 0 asynchronously; subsequent D5, 01, 77 yields 77.
